// File: rtl/firefly_period_meter_if.sv
`timescale 1ns/1ps
// Signal bundle between the flash-follower control (master) and the period meter (slave).
interface firefly_period_meter_if #(
    parameter int PW = 20
);
    logic          en;
    logic          f0;
    logic [PW-1:0] period_o;
    logic [PW-1:0] high_o;
    logic          valid_o;
    logic          locked_o;
    logic          lost_o;

    modport master (output en, f0, input period_o, high_o, valid_o, locked_o, lost_o);
    modport slave  (input en, f0, output period_o, high_o, valid_o, locked_o, lost_o);
endinterface

// File: rtl/firefly_period_meter.sv
`timescale 1ns/1ps
// Flash-input front end: synchronises and glitch-filters f0, then publishes period and
// high-time averages over 2**AVG_LOG2 periods with a valid strobe and lock/loss status.
module firefly_period_meter #(
    parameter int PW       = 20,
    parameter int AVG_LOG2 = 2,
    parameter int FILT     = 4,
    parameter int TIMEOUT  = 300000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    firefly_period_meter_if.slave bus
);
    localparam int AW = PW + AVG_LOG2;
    localparam int FW = $clog2(FILT + 1);
    localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [PW-1:0] TMO   = PW'(TIMEOUT);
    localparam logic [FW-1:0] FLAST = FW'(FILT - 1);
    localparam logic [NW-1:0] NLAST = NW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    logic          sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [FW-1:0] stab_q;
    logic          rise_s, fall_s;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, hsample_q, hsample_d;
    logic [AW-1:0] psum_q, psum_d, hsum_q, hsum_d, psum_add_s, hsum_add_s;
    logic [NW-1:0] n_q, n_d;
    logic [PW-1:0] period_q, period_d, high_q, high_d;
    logic          valid_q, valid_d, locked_q, locked_d, lost_q, lost_d;

    // Two-flop synchroniser and stability filter; filt_q only moves after FILT agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            stab_q      <= '0;
        end else begin
            sync1_q     <= bus.f0;
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            if (sync2_q != filt_q) begin
                if (stab_q == FLAST) begin
                    filt_q <= sync2_q;
                    stab_q <= '0;
                end else begin
                    stab_q <= stab_q + 1'b1;
                end
            end else begin
                stab_q <= '0;
            end
        end
    end

    assign rise_s     = filt_q & ~filt_prev_q;
    assign fall_s     = ~filt_q & filt_prev_q;
    assign psum_add_s = psum_q + AW'(cnt_q);
    assign hsum_add_s = hsum_q + AW'(hsample_q);

    // Measurement FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            hsample_q <= '0;
            psum_q    <= '0;
            hsum_q    <= '0;
            n_q       <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            hsample_q <= hsample_d;
            psum_q    <= psum_d;
            hsum_q    <= hsum_d;
            n_q       <= n_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            lost_q    <= lost_d;
        end
    end

    // Next-state logic; a rise in the timeout cycle wins, so a period of exactly TIMEOUT is kept.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        hsample_d = hsample_q;
        psum_d    = psum_q;
        hsum_d    = hsum_q;
        n_d       = n_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        lost_d    = lost_q;
        if (!bus.en) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            hcnt_d    = '0;
            hsample_d = '0;
            psum_d    = '0;
            hsum_d    = '0;
            n_d       = '0;
            locked_d  = 1'b0;
            lost_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        state_d = ST_RUN;
                        cnt_d   = PW'(1);
                        hcnt_d  = PW'(1);
                    end else begin
                        cnt_d  = '0;
                        hcnt_d = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d  = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
                    hcnt_d = filt_q ? hcnt_q + 1'b1 : hcnt_q;
                    if (fall_s) begin
                        hsample_d = hcnt_q;
                    end else begin
                        hsample_d = hsample_q;
                    end
                    if (rise_s) begin
                        cnt_d  = PW'(1);
                        hcnt_d = PW'(1);
                        if (n_q == NLAST) begin
                            period_d = PW'(psum_add_s >> AVG_LOG2);
                            high_d   = PW'(hsum_add_s >> AVG_LOG2);
                            valid_d  = 1'b1;
                            locked_d = 1'b1;
                            lost_d   = 1'b0;
                            psum_d   = '0;
                            hsum_d   = '0;
                            n_d      = '0;
                        end else begin
                            psum_d = psum_add_s;
                            hsum_d = hsum_add_s;
                            n_d    = n_q + 1'b1;
                        end
                    end else if (cnt_q == TMO) begin
                        state_d  = ST_ARM;
                        lost_d   = 1'b1;
                        locked_d = 1'b0;
                        cnt_d    = '0;
                        hcnt_d   = '0;
                        psum_d   = '0;
                        hsum_d   = '0;
                        n_d      = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.period_o = period_q;
    assign bus.high_o   = high_q;
    assign bus.valid_o  = valid_q;
    assign bus.locked_o = locked_q;
    assign bus.lost_o   = lost_q;
endmodule

// File: tb/tb_firefly_period_meter.sv
`timescale 1ns/1ps
// Bench for firefly_period_meter: an edge-schedule model predicts each valid_o and lost_o
// event (cycle and values) from the driven f0 waveform; a monitor records what the DUT does.
module tb_firefly_period_meter;
    localparam int PW       = 12;
    localparam int AVG_LOG2 = 2;
    localparam int FILT     = 4;
    localparam int TIMEOUT  = 3000;
    localparam int NAVG     = 1 << AVG_LOG2;
    localparam int LAT      = FILT + 3;

    typedef struct {int c; int p; int h;} ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    firefly_period_meter_if #(.PW(PW)) bus ();

    firefly_period_meter #(.PW(PW), .AVG_LOG2(AVG_LOG2), .FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Monitor: every valid strobe and every lost_o assertion, plus flag/stability sanity.
    ev_t  obs_v[$], exp_v[$];
    int   obs_l[$], exp_l[$];
    int   stray_chg = 0;
    int   bad_flags = 0;
    logic [PW-1:0] last_p = '0, last_h = '0;
    logic last_lost = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_p    = '0;
            last_h    = '0;
            last_lost = 1'b0;
        end else begin
            if (bus.valid_o) begin
                obs_v.push_back('{cyc, int'(bus.period_o), int'(bus.high_o)});
                if (!bus.locked_o || bus.lost_o) bad_flags++;
            end else if (bus.period_o != last_p || bus.high_o != last_h) begin
                stray_chg++;
            end
            if (bus.lost_o && !last_lost) begin
                obs_l.push_back(cyc);
                if (bus.locked_o) bad_flags++;
            end
            last_p    = bus.period_o;
            last_h    = bus.high_o;
            last_lost = bus.lost_o;
        end
    end

    // Reference model over driven edge times (cycle index of the drive).
    bit m_en = 1'b0, m_sess = 1'b0;
    int m_last_rise = 0, m_h = 0, m_k = 0, m_ps = 0, m_hs = 0;

    function automatic void m_advance(input int c);
        if (m_sess && (c - m_last_rise > TIMEOUT)) begin
            exp_l.push_back(m_last_rise + LAT + TIMEOUT);
            m_sess = 1'b0;
        end
    endfunction

    function automatic void m_rise(input int c);
        m_advance(c);
        if (!m_en) return;
        if (!m_sess) begin
            m_sess = 1'b1;
            m_k    = 0;
            m_ps   = 0;
            m_hs   = 0;
        end else begin
            m_ps += c - m_last_rise;
            m_hs += m_h;
            m_k++;
            if (m_k == NAVG) begin
                exp_v.push_back('{c + LAT, m_ps >> AVG_LOG2, m_hs >> AVG_LOG2});
                m_k  = 0;
                m_ps = 0;
                m_hs = 0;
            end
        end
        m_last_rise = c;
    endfunction

    function automatic void m_fall(input int c);
        if (m_sess) m_h = c - m_last_rise;
    endfunction

    task automatic set_f0(input logic v);
        @(posedge clk); #1;
        if (v && !bus.f0) m_rise(cyc);
        else if (!v && bus.f0) m_fall(cyc);
        bus.f0 = v;
    endtask

    task automatic pulse(input int h, input int l);
        set_f0(1'b1);
        repeat (h - 1) @(posedge clk);
        set_f0(1'b0);
        repeat (l - 1) @(posedge clk);
    endtask

    // Same period as pulse(h,l) but with a 2-cycle high glitch 10 cycles into the low phase.
    task automatic pulse_glitch(input int h, input int l);
        set_f0(1'b1);
        repeat (h - 1) @(posedge clk);
        set_f0(1'b0);
        repeat (9) @(posedge clk);
        @(posedge clk); #1 bus.f0 = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 bus.f0 = 1'b0;
        repeat (l - 13) @(posedge clk);
    endtask

    task automatic set_en(input logic v);
        @(posedge clk); #1;
        m_advance(cyc);
        bus.en = v;
        m_en   = v;
        if (!v) m_sess = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reconcile(input string ph);
        settle(LAT + 2);
        m_advance(cyc - LAT + 1);
        chk_eq({ph, "_nvalid"}, obs_v.size(), exp_v.size());
        for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
            chk_eq({ph, "_vcyc"},   obs_v[i].c, exp_v[i].c);
            chk_eq({ph, "_period"}, obs_v[i].p, exp_v[i].p);
            chk_eq({ph, "_high"},   obs_v[i].h, exp_v[i].h);
        end
        chk_eq({ph, "_nlost"}, obs_l.size(), exp_l.size());
        for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
            chk_eq({ph, "_lostcyc"}, obs_l[i], exp_l[i]);
        end
        obs_v.delete(); exp_v.delete(); obs_l.delete(); exp_l.delete();
    endtask

    task automatic chk_outputs_zero(input string ph);
        chk_eq({ph, "_period0"}, bus.period_o, 0);
        chk_eq({ph, "_high0"},   bus.high_o, 0);
        chk_eq({ph, "_valid0"},  bus.valid_o, 0);
        chk_eq({ph, "_locked0"}, bus.locked_o, 0);
        chk_eq({ph, "_lost0"},   bus.lost_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0;
        bus.f0 = 1'b0;
        settle(3);
        chk_outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // 1 kHz scaled: period 500, high 125.
        set_en(1'b1);
        repeat (20) @(posedge clk);
        for (int i = 0; i < 6; i++) pulse(125, 375);
        reconcile("base");
        chk_eq("base_locked", bus.locked_o, 1);
        chk_eq("base_period", bus.period_o, 500);
        chk_eq("base_high",   bus.high_o, 125);

        for (int i = 0; i < 8; i++) pulse_glitch(125, 375);
        reconcile("glitch");
        chk_eq("glitch_period", bus.period_o, 500);
        chk_eq("glitch_high",   bus.high_o, 125);

        for (int i = 0; i < 6; i++) pulse(250, 750);
        for (int i = 0; i < 10; i++) pulse(75, 340);
        reconcile("switch");

        for (int i = 0; i < 30; i++) pulse($urandom_range(FILT + 1, 300), $urandom_range(FILT + 1, 300));
        reconcile("random");

        // Rise landing exactly on TIMEOUT keeps the sample; one cycle later declares loss.
        pulse(100, TIMEOUT - 100);
        pulse(100, TIMEOUT - 99);
        for (int i = 0; i < 5; i++) pulse(125, 375);
        reconcile("bound");

        repeat (3500) @(posedge clk);
        @(negedge clk);
        chk_eq("loss_lost",   bus.lost_o, 1);
        chk_eq("loss_locked", bus.locked_o, 0);
        for (int i = 0; i < 5; i++) pulse(125, 375);
        reconcile("relock");
        chk_eq("relock_lost",   bus.lost_o, 0);
        chk_eq("relock_locked", bus.locked_o, 1);

        pulse(125, 375);
        pulse(125, 375);
        set_en(1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("endrop_locked", bus.locked_o, 0);
        chk_eq("endrop_lost",   bus.lost_o, 0);
        chk_eq("endrop_valid",  bus.valid_o, 0);
        repeat (50) @(posedge clk);
        set_en(1'b1);
        repeat (20) @(posedge clk);
        for (int i = 0; i < 6; i++) pulse(150, 350);
        reconcile("rearm");

        pulse(125, 375);
        pulse(125, 375);
        set_f0(1'b1);
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        bus.en = 1'b0;
        m_en   = 1'b0;
        m_sess = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) pulse(60, 90);
        reconcile("noen");
        chk_outputs_zero("noen");

        chk_eq("stray_output_change", stray_chg, 0);
        chk_eq("status_flags_at_events", bad_flags, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
